// File: rtl/reg_wr_arb_if.sv
// Write-request bus between NREQ requesters and the register-bank write port.
// The master side drives the requests; the slave side is the arbiter.
interface reg_wr_arb_if #(
   parameter int NREQ = 4,
   parameter int DW   = 8,
   parameter int AW   = 2
);
   localparam int NREG = 2**AW;

   logic [NREQ-1:0]    req_vld;
   logic [NREQ-1:0]    req_lock;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_rdy;
   logic [NREG-1:0]    ld_en;
   logic [DW-1:0]      ld_din;
   logic [NREQ-1:0]    lock_own;

   modport master (
      output req_vld, req_lock, req_addr, req_data,
      input  req_rdy, ld_en, ld_din, lock_own
   );

   modport slave (
      input  req_vld, req_lock, req_addr, req_data,
      output req_rdy, ld_en, ld_din, lock_own
   );
endinterface

// File: rtl/reg_wr_arb.sv
// Round-robin write arbiter with lock for a register bank.
// The winner's write becomes a registered one-hot load enable plus data one cycle later.
module reg_wr_arb #(
   parameter int NREQ = 4,
   parameter int DW   = 8,
   parameter int AW   = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   reg_wr_arb_if.slave  bus
);
   localparam int NREG = 2**AW;
   localparam int PW   = $clog2(NREQ);

   typedef enum logic {ARB, LOCK} state_t;

   state_t          state;
   logic [PW-1:0]   ptr, owner, win, nxt_ptr, idx;
   logic [NREQ-1:0] rdy;
   logic            found, xfer, wlock;
   logic [AW-1:0]   waddr;
   logic [DW-1:0]   wdata;

   // Grant is combinational; while locked only the owner can be accepted.
   always_comb begin
      rdy   = '0;
      found = 1'b0;
      idx   = '0;
      if (rst_n) begin
         if (state == LOCK) begin
            rdy[owner] = bus.req_vld[owner];
         end else begin
            for (int k = 0; k < NREQ; k++) begin
               idx = PW'((int'(ptr) + k) % NREQ);
               if (!found && bus.req_vld[idx]) begin
                  rdy[idx] = 1'b1;
                  found    = 1'b1;
               end
            end
         end
      end
      win = '0;
      for (int i = 0; i < NREQ; i++)
         if (rdy[i]) win = PW'(i);
   end

   assign xfer        = |rdy;
   assign wlock       = bus.req_lock[win];
   assign waddr       = bus.req_addr[int'(win)*AW +: AW];
   assign wdata       = bus.req_data[int'(win)*DW +: DW];
   assign nxt_ptr     = (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
   assign bus.req_rdy = rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ARB;
         ptr          <= '0;
         owner        <= '0;
         bus.ld_en    <= '0;
         bus.ld_din   <= '0;
         bus.lock_own <= '0;
      end else begin
         bus.ld_en <= '0;
         if (xfer) begin
            bus.ld_en  <= NREG'(1) << waddr;
            bus.ld_din <= wdata;
            case (state)
               ARB: begin
                  ptr <= nxt_ptr;
                  if (wlock) begin
                     state        <= LOCK;
                     owner        <= win;
                     bus.lock_own <= NREQ'(1) << win;
                  end
               end
               LOCK: begin
                  // ptr stays put while the owner keeps the lock
                  if (!wlock) begin
                     state        <= ARB;
                     ptr          <= nxt_ptr;
                     bus.lock_own <= '0;
                  end
               end
               default: state <= ARB;
            endcase
         end
      end
   end
endmodule
